pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter and branch sequencer for the SAP-2 CPU core. It replaces the fixed-width counter-plus-JN decode with one block that does several things. It evaluates all conditional-jump variants against the Z/C/N flags. It supports subroutine call/return through an internal return-address stack of configurable depth. It latches halt. The control unit drives its command strobes once per micro-step, and its `pc_out` feeds the memory address register.

## Interface
- `ADDR_WIDTH`, 8, width of PC, jump target and stack entries
- `STACK_DEPTH`, 4, number of return-address stack entries (≥1)
- `SP_WIDTH`, $clog2(STACK_DEPTH+1), width of `sp_count` (derived, not overridden)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk`
- `pc_inc`  in  1  increment PC (fetch / operand-fetch step)
- `pc_load`  in  1  conditional jump request using `cond`, `target`
- `call`  in  1  conditional call request using `cond`, `target`
- `ret`  in  1  return: pop stack into PC
- `halt_req`  in  1  enter HALTED
- `cond`  in  3  condition code, see Operation
- `target`  in  ADDR_WIDTH  jump/call destination
- `flag_zero`, `flag_carry`, `flag_negative`  in  1 each  ALU flags
- `pc_out`  out  ADDR_WIDTH  current PC
- `taken`  out  1  one-cycle pulse: a jump, call or return changed PC on the previous edge
- `halted`  out  1  high in HALTED
- `sp_count`  out  SP_WIDTH  valid stack entries
- `stack_overflow`  out  1  sticky: call attempted with stack full
- `stack_underflow`  out  1  sticky: ret attempted with stack empty

## Operation
- Condition decode:
  - `cond[1:0]`: 00 = always, 01 = Z, 10 = C, 11 = N.
  - Result = `cond[2]` XOR selected term.
  - Codes: 000 JMP, 001 JZ, 010 JC, 011 JN, 100 never, 101 JNZ, 110 JNC, 111 JNN.
- Flags are sampled at the same edge as the command. There is no flag latency inside the block.
- States: RUN, HALTED.
- RUN → HALTED on `halt_req`.
- HALTED → RUN only via `reset`.
- In HALTED, all command inputs are ignored and PC and stack are frozen.
- Command priority per cycle, highest first: `halt_req` > `ret` > `call` > `pc_load` > `pc_inc`. Lower-priority strobes in the same cycle are ignored, except that a not-taken `pc_load` or `call` falls through to `pc_inc` if it is asserted.
- `pc_inc`: PC ← PC+1 modulo 2^ADDR_WIDTH. 0xFF → 0x00 at the default width.
- `pc_load` with condition true: PC ← `target`, `taken` pulses. Condition false: PC unchanged, or incremented if `pc_inc` is also high.
- `call` with condition true and `sp_count` < STACK_DEPTH:
  - push current PC (already the return address, since the operand fetch incremented it)
  - PC ← `target`
  - `sp_count`+1, `taken` pulses
- `call` with condition true and stack full: no push, PC unchanged, `stack_overflow` ← 1.
- `ret` with `sp_count` > 0: PC ← top entry, `sp_count`−1, `taken` pulses.
- `ret` with stack empty: PC unchanged, `stack_underflow` ← 1.
- The stack is LIFO with no wrap. Entries above `sp_count` are don't-care.
- Sticky error flags clear only on `reset`.

## Timing
- All outputs are registered. A command sampled at edge k is visible on `pc_out` after edge k; `taken` is high for exactly the cycle following edge k.
- Reset (low at a rising edge) takes effect at that edge and overrides every command, including mid-call and while halted. Values after reset:
  - `pc_out` = 0
  - `taken` = 0
  - `halted` = 0
  - `sp_count` = 0
  - `stack_overflow` = 0
  - `stack_underflow` = 0
  - state RUN
- Single-cycle latency for every command. Back-to-back calls and returns on consecutive cycles are supported.
- `halt_req` in the same cycle as a taken jump: halt wins and PC does not change. `halted` goes high after that edge.

## Test plan
- JN taken/not taken:
  - PC=0x01, N=1, `pc_load`, cond=011, target=0x06 → PC=0x06, `taken`=1 for one cycle.
  - Then N=0, `pc_load`+`pc_inc`, cond=011, target=0x0C, PC=0x07 → PC=0x08, `taken`=0.
- Full condition sweep: each of the 8 codes against each Z/C/N combination with target=0xA5. PC=0xA5 exactly when the decode table gives true. Code 100 never jumps.
- Call/return nesting, STACK_DEPTH=4:
  - calls from PC=0x10, 0x20, 0x30, 0x40 → `sp_count`=4.
  - fifth call → `stack_overflow`=1, PC unchanged.
  - four rets → PC returns 0x40, 0x30, 0x20, 0x10.
  - fifth ret → `stack_underflow`=1, PC unchanged.
- Wrap and priority:
  - PC=0xFF + `pc_inc` → 0x00.
  - `ret`+`pc_load`+`pc_inc` together with stack holding 0x33 → PC=0x33.
- Halt: `halt_req` with `pc_load` cond=000 at PC=0x0A → PC stays 0x0A, `halted`=1. Later `pc_inc` pulses are ignored.
- Reset mid-operation: `reset`=0 during a call with `sp_count`=2 and both error flags set → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with conditional jump/call/return, a
// return-address stack and a halt latch. One command resolves per clock.
module pc_sequencer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_inc,
    input  logic                  pc_load,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  halt_req,
    input  logic [2:0]            cond,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  flag_zero,
    input  logic                  flag_carry,
    input  logic                  flag_negative,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  taken,
    output logic                  halted,
    output logic [SP_WIDTH-1:0]   sp_count,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    // Stack index width; a one-entry stack still needs a one-bit index.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0]   SP_FULL = SP_WIDTH'(STACK_DEPTH);
    localparam logic [SP_WIDTH-1:0]   SP_ONE  = SP_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SP_WIDTH-1:0]   sp_q, sp_d;
    logic                  taken_q, taken_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // Entries at or above sp_q are stale and never read.
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                  push;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      top_idx;

    logic                  cond_sel;
    logic                  cond_true;
    logic [ADDR_WIDTH-1:0] pc_plus1;

    assign push_idx = IDX_W'(sp_q);
    assign top_idx  = IDX_W'(sp_q - SP_ONE);
    assign pc_plus1 = pc_q + PC_ONE;

    // Condition decode: select a flag term, cond[2] inverts it.
    always_comb begin
        cond_sel = 1'b1;
        case (cond[1:0])
            2'b00:   cond_sel = 1'b1;
            2'b01:   cond_sel = flag_zero;
            2'b10:   cond_sel = flag_carry;
            default: cond_sel = flag_negative;
        endcase
        cond_true = cond[2] ^ cond_sel;
    end

    // Next-state and command resolution, priority halt > ret > call > load > inc.
    // A call/load whose condition is false falls through to pc_inc only;
    // a true call with a full stack does nothing but raise the overflow flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        taken_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (state_q == ST_RUN) begin
            if (halt_req) begin
                state_d = ST_HALTED;
            end else if (ret) begin
                if (sp_q != '0) begin
                    pc_d    = stack_mem[top_idx];
                    sp_d    = sp_q - SP_ONE;
                    taken_d = 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end else if (call) begin
                if (cond_true) begin
                    if (sp_q < SP_FULL) begin
                        push    = 1'b1;
                        pc_d    = target;
                        sp_d    = sp_q + SP_ONE;
                        taken_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (pc_inc) begin
                    pc_d = pc_plus1;
                end
            end else if (pc_load) begin
                if (cond_true) begin
                    pc_d    = target;
                    taken_d = 1'b1;
                end else if (pc_inc) begin
                    pc_d = pc_plus1;
                end
            end else if (pc_inc) begin
                pc_d = pc_plus1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            sp_q    <= '0;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address push; the current PC is already the return address.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            stack_mem[push_idx] <= pc_q;
        end
    end

    assign pc_out          = pc_q;
    assign taken           = taken_q;
    assign halted          = (state_q == ST_HALTED);
    assign sp_count        = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
